// File: rtl/lc3_io_ctrl.sv
// LC-3 memory-mapped I/O control: address decode, display device (DDR/DSR
// plus 4-digit multiplexed 7-segment driver) and interrupt priority/vector logic.
module lc3_io_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        R_W,
  input  logic        MIO_EN,
  input  logic [15:0] KBSR,
  input  logic [15:0] UARTSR,
  input  logic [1:0]  VectorMUX,
  input  logic        LD_Vector,
  output logic [3:0]  INMUX_Sel,
  output logic        MEM_EN,
  output logic        LD_KBSR,
  output logic        LD_DDR,
  output logic        LD_DSR,
  output logic        LD_SDAER,
  output logic        LD_SDADR,
  output logic        LD_SDASR,
  output logic        LD_SCLER,
  output logic        LD_UARTDR,
  output logic        LD_UARTSR,
  output logic [2:0]  LD_SC_buffer,
  output logic [15:0] DSR,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        WR_DSP,
  output logic [7:0]  Vector,
  output logic [2:0]  INT_Priority
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [15:0]   ddr;
  logic          dsr_ready;
  logic          dsr_ie;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit;
  logic [3:0]    nibble;
  logic          kb_req, uart_req, dsp_req;
  logic [7:0]    pend_vec;
  logic          unused_sr;

  assign unused_sr = ^{KBSR[13:0], UARTSR[13:0]};

  // Address decode
  always_comb begin
    INMUX_Sel    = '1;
    MEM_EN       = MIO_EN && (MAR < 16'hFE00);
    LD_KBSR      = 1'b0;
    LD_DDR       = 1'b0;
    LD_DSR       = 1'b0;
    LD_SDAER     = 1'b0;
    LD_SDADR     = 1'b0;
    LD_SDASR     = 1'b0;
    LD_SCLER     = 1'b0;
    LD_UARTDR    = 1'b0;
    LD_UARTSR    = 1'b0;
    LD_SC_buffer = '0;
    if (MIO_EN && !R_W) begin
      if (MAR < 16'hFE00) INMUX_Sel = 4'b0000;
      else begin
        case (MAR)
          16'hFE00: INMUX_Sel = 4'b0001;
          16'hFE02: INMUX_Sel = 4'b0010;
          16'hFE04: INMUX_Sel = 4'b0011;
          16'hFE08: INMUX_Sel = 4'b0100;
          16'hFE0A: INMUX_Sel = 4'b0101;
          16'hFE0C: INMUX_Sel = 4'b0110;
          16'hFE0E: INMUX_Sel = 4'b0111;
          16'hFE10: INMUX_Sel = 4'b1000;
          16'hFE12: INMUX_Sel = 4'b1001;
          16'hFE14: INMUX_Sel = 4'b1010;
          16'hFE16: INMUX_Sel = 4'b1011;
          default: begin
            if (MAR[15:3] == 13'h1FC4) INMUX_Sel = 4'b1100;
            if (MAR[15:3] == 13'h1FC5) INMUX_Sel = 4'b1101;
            if (MAR[15:3] == 13'h1FC6) INMUX_Sel = 4'b1110;
          end
        endcase
      end
    end
    if (MIO_EN && R_W) begin
      case (MAR)
        16'hFE00: LD_KBSR   = 1'b1;
        16'hFE04: LD_DSR    = 1'b1;
        16'hFE06: LD_DDR    = 1'b1;
        16'hFE0A: LD_SDAER  = 1'b1;
        16'hFE0C: LD_SDADR  = 1'b1;
        16'hFE0E: LD_SDASR  = 1'b1;
        16'hFE12: LD_SCLER  = 1'b1;
        16'hFE16: LD_UARTSR = 1'b1;
        16'hFE18: LD_UARTDR = 1'b1;
        default: begin
          LD_SC_buffer[0] = (MAR[15:3] == 13'h1FC4);
          LD_SC_buffer[1] = (MAR[15:3] == 13'h1FC5);
          LD_SC_buffer[2] = (MAR[15:3] == 13'h1FC6);
        end
      endcase
    end
  end

  // Display registers; ready is low for exactly the cycles following a DDR strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ddr       <= '0;
      dsr_ie    <= 1'b0;
      dsr_ready <= 1'b1;
      WR_DSP    <= 1'b0;
    end else begin
      if (LD_DDR) ddr <= MDR;
      if (LD_DSR) dsr_ie <= MDR[14];
      dsr_ready <= ~LD_DDR;
      WR_DSP    <= LD_DDR | LD_DSR;
    end
  end

  assign DSR = {dsr_ready, dsr_ie, 14'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else if (scan_cnt == CW'(REFRESH_DIV - 1)) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign nibble = ddr[{digit, 2'b00} +: 4];
  assign an     = ~(4'b0001 << digit);

  always_comb begin
    seg = '1;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

  // Interrupt arbitration: KB > UART > display
  assign kb_req   = KBSR[15] & KBSR[14];
  assign uart_req = UARTSR[15] & UARTSR[14];
  assign dsp_req  = dsr_ready & dsr_ie;

  always_comb begin
    INT_Priority = 3'd0;
    pend_vec     = 8'h00;
    if (kb_req) begin
      INT_Priority = 3'd4;
      pend_vec     = 8'h80;
    end else if (uart_req) begin
      INT_Priority = 3'd3;
      pend_vec     = 8'h82;
    end else if (dsp_req) begin
      INT_Priority = 3'd2;
      pend_vec     = 8'h81;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) Vector <= 8'h00;
    else if (LD_Vector) begin
      case (VectorMUX)
        2'b00:   Vector <= pend_vec;
        2'b01:   Vector <= 8'h00;
        2'b10:   Vector <= 8'h01;
        default: Vector <= Vector;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_io_ctrl.sv
// Self-checking bench for lc3_io_ctrl: randomized decode and arbitration
// against a behavioural model, plus display write, scan and reset scenarios.
module tb_lc3_io_ctrl;
  localparam int unsigned RD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] MAR, MDR, KBSR, UARTSR;
  logic        R_W, MIO_EN, LD_Vector;
  logic [1:0]  VectorMUX;
  logic [3:0]  INMUX_Sel;
  logic        MEM_EN, LD_KBSR, LD_DDR, LD_DSR, LD_SDAER, LD_SDADR, LD_SDASR;
  logic        LD_SCLER, LD_UARTDR, LD_UARTSR, WR_DSP;
  logic [2:0]  LD_SC_buffer, INT_Priority;
  logic [15:0] DSR;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [7:0]  Vector;

  int passed = 0;
  int total  = 0;
  int ncyc   = 0;
  logic [15:0] ddr_m;
  logic        ie_m;
  logic [7:0]  vec_m;

  lc3_io_ctrl #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .MAR(MAR), .MDR(MDR), .R_W(R_W), .MIO_EN(MIO_EN),
    .KBSR(KBSR), .UARTSR(UARTSR), .VectorMUX(VectorMUX), .LD_Vector(LD_Vector),
    .INMUX_Sel(INMUX_Sel), .MEM_EN(MEM_EN), .LD_KBSR(LD_KBSR), .LD_DDR(LD_DDR),
    .LD_DSR(LD_DSR), .LD_SDAER(LD_SDAER), .LD_SDADR(LD_SDADR), .LD_SDASR(LD_SDASR),
    .LD_SCLER(LD_SCLER), .LD_UARTDR(LD_UARTDR), .LD_UARTSR(LD_UARTSR),
    .LD_SC_buffer(LD_SC_buffer), .DSR(DSR), .seg(seg), .an(an), .WR_DSP(WR_DSP),
    .Vector(Vector), .INT_Priority(INT_Priority)
  );

  always #5 clk = ~clk;

  // Non-reset edges since the last reset edge
  always @(posedge clk) begin
    if (!rst_n) ncyc <= 0;
    else ncyc <= ncyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {sel, mem_en, KBSR, DDR, DSR, SDAER, SDADR, SDASR, SCLER, UARTDR, UARTSR, SC[2:0]}
  function automatic logic [16:0] exp_dec(input logic [15:0] a, input logic rw, input logic en);
    logic [3:0]  sel;
    logic [11:0] st;
    int unsigned blk;
    sel = 4'hF;
    st  = '0;
    blk = (a >= 16'hFE20 && a <= 16'hFE37) ? (int'(a) - 'hFE20) / 8 : 99;
    if (en && !rw) begin
      if (a < 16'hFE00) sel = 4'h0;
      else if (blk < 3) sel = 4'(12 + blk);
      else begin
        case (a)
          16'hFE00: sel = 4'h1;  16'hFE02: sel = 4'h2;  16'hFE04: sel = 4'h3;
          16'hFE08: sel = 4'h4;  16'hFE0A: sel = 4'h5;  16'hFE0C: sel = 4'h6;
          16'hFE0E: sel = 4'h7;  16'hFE10: sel = 4'h8;  16'hFE12: sel = 4'h9;
          16'hFE14: sel = 4'hA;  16'hFE16: sel = 4'hB;
          default: sel = 4'hF;
        endcase
      end
    end
    if (en && rw) begin
      if (blk < 3) st[blk] = 1'b1;
      case (a)
        16'hFE00: st[11] = 1'b1;  16'hFE06: st[10] = 1'b1;  16'hFE04: st[9] = 1'b1;
        16'hFE0A: st[8]  = 1'b1;  16'hFE0C: st[7]  = 1'b1;  16'hFE0E: st[6] = 1'b1;
        16'hFE12: st[5]  = 1'b1;  16'hFE18: st[4]  = 1'b1;  16'hFE16: st[3] = 1'b1;
        default: ;
      endcase
    end
    return {sel, en && (a < 16'hFE00), st};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  // Highest pending request: returns {priority, vector}
  function automatic logic [10:0] pend(input logic [15:0] kb, input logic [15:0] ua, input logic ie);
    int best_p = 0;
    int best_v = 0;
    if (ie && best_p < 2) begin best_p = 2; best_v = 'h81; end
    if (ua[15] && ua[14] && best_p < 3) begin best_p = 3; best_v = 'h82; end
    if (kb[15] && kb[14] && best_p < 4) begin best_p = 4; best_v = 'h80; end
    return {3'(best_p), 8'(best_v)};
  endfunction

  function automatic logic [16:0] act_dec();
    return {INMUX_Sel, MEM_EN, LD_KBSR, LD_DDR, LD_DSR, LD_SDAER, LD_SDADR, LD_SDASR,
            LD_SCLER, LD_UARTDR, LD_UARTSR, LD_SC_buffer};
  endfunction

  task automatic test_reset();
    total++;
    if (DSR !== 16'h8000 || an !== 4'b1110 || Vector !== 8'h00 || WR_DSP !== 1'b0 || seg !== 7'h40)
      $display("FAIL reset: DSR=%h an=%b Vector=%h WR_DSP=%b seg=%h, want 8000 1110 00 0 40",
               DSR, an, Vector, WR_DSP, seg);
    else passed++;
  endtask

  task automatic test_decode();
    logic [15:0] dir [12];
    logic [16:0] e;
    dir = '{16'h3000, 16'hFE00, 16'hFE02, 16'hFE16, 16'hFE25, 16'hFE06, 16'hFFFF,
            16'hFE06, 16'hFE04, 16'hFE18, 16'hFE2A, 16'hFE02};
    for (int i = 0; i < 72; i++) begin
      if (i < 12) begin
        MAR = dir[i]; R_W = (i >= 7); MIO_EN = 1'b1;
      end else begin
        MAR = ($urandom_range(0, 1) == 1) ? 16'hFE00 + 16'($urandom_range(0, 63)) : 16'($urandom);
        R_W = 1'($urandom); MIO_EN = ($urandom_range(0, 3) != 0);
      end
      MDR = 16'h0;
      #1;
      e = exp_dec(MAR, R_W, MIO_EN);
      total++;
      if (act_dec() !== e)
        $display("FAIL decode MAR=%h RW=%b EN=%b: got %b want %b", MAR, R_W, MIO_EN, act_dec(), e);
      else passed++;
      MIO_EN = 1'b0;
      step();
    end
    ddr_m = 16'h0; ie_m = 1'b0;
  endtask

  task automatic test_display_write();
    MAR = 16'hFE06; R_W = 1'b1; MDR = 16'h12AF; MIO_EN = 1'b1;
    #1;
    total++;
    if (WR_DSP !== 1'b0) $display("FAIL wr_dsp_first: got %b want 0", WR_DSP); else passed++;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (WR_DSP !== 1'b1 || DSR[15] !== 1'b0)
        $display("FAIL ddr_hold c%0d: WR_DSP=%b ready=%b want 1 0", c, WR_DSP, DSR[15]);
      else passed++;
    end
    MIO_EN = 1'b0;
    ddr_m = 16'h12AF;
    step();
    total++;
    if (WR_DSP !== 1'b0 || DSR[15] !== 1'b1)
      $display("FAIL ddr_release: WR_DSP=%b ready=%b want 0 1", WR_DSP, DSR[15]);
    else passed++;
  endtask

  task automatic test_scan();
    int d;
    for (int c = 0; c < 16; c++) begin
      d = (ncyc / RD) % 4;
      total++;
      if (an !== ~(4'b0001 << d) || seg !== seg_of(ddr_m[4*d +: 4]))
        $display("FAIL scan c%0d: an=%b seg=%b want an=%b seg=%b",
                 c, an, seg, ~(4'b0001 << d), seg_of(ddr_m[4*d +: 4]));
      else passed++;
      step();
    end
  endtask

  task automatic write_dsr(input logic ie);
    MAR = 16'hFE04; R_W = 1'b1; MDR = {1'b0, ie, 14'h0}; MIO_EN = 1'b1;
    step();
    MIO_EN = 1'b0;
    ie_m = ie;
  endtask

  task automatic test_dsr_write();
    write_dsr(1'b1);
    total++;
    if (DSR !== 16'hC000) $display("FAIL dsr_write: got %h want C000", DSR); else passed++;
  endtask

  task automatic pulse_vec(input logic [1:0] m, input logic ld);
    logic [10:0] p;
    p = pend(KBSR, UARTSR, ie_m);
    VectorMUX = m; LD_Vector = ld;
    step();
    LD_Vector = 1'b0;
    if (ld) begin
      case (m)
        2'b00: vec_m = p[7:0];
        2'b01: vec_m = 8'h00;
        2'b10: vec_m = 8'h01;
        default: vec_m = vec_m;
      endcase
    end
  endtask

  task automatic check_arb(input string nm);
    logic [10:0] p;
    p = pend(KBSR, UARTSR, ie_m);
    total++;
    if (INT_Priority !== p[10:8] || Vector !== vec_m)
      $display("FAIL %s: pri=%0d vec=%h want pri=%0d vec=%h", nm, INT_Priority, Vector, p[10:8], vec_m);
    else passed++;
  endtask

  task automatic test_arbitration();
    write_dsr(1'b0);
    KBSR = 16'hC000; UARTSR = 16'hC000; #1; pulse_vec(2'b00, 1'b1); check_arb("arb_kb");
    KBSR = 16'h0000; #1; pulse_vec(2'b00, 1'b1); check_arb("arb_uart");
    UARTSR = 16'h0000; write_dsr(1'b1); pulse_vec(2'b00, 1'b1); check_arb("arb_dsp");
    write_dsr(1'b0); UARTSR = 16'h8000; #1; pulse_vec(2'b00, 1'b1); check_arb("arb_none");
    pulse_vec(2'b10, 1'b1); check_arb("exc_illegal");
    pulse_vec(2'b11, 1'b1); check_arb("exc_hold");
    pulse_vec(2'b01, 1'b0); check_arb("exc_noload");
    pulse_vec(2'b01, 1'b1); check_arb("exc_priv");
    for (int i = 0; i < 24; i++) begin
      KBSR   = {2'($urandom), 14'($urandom)};
      UARTSR = {2'($urandom), 14'($urandom)};
      if ($urandom_range(0, 2) == 0) write_dsr(1'($urandom));
      #1;
      pulse_vec(2'($urandom), ($urandom_range(0, 3) != 0));
      check_arb("arb_rand");
    end
  endtask

  task automatic test_reset_override();
    MAR = 16'hFE06; R_W = 1'b1; MDR = 16'hFFFF; MIO_EN = 1'b1;
    VectorMUX = 2'b10; LD_Vector = 1'b1; rst_n = 1'b0;
    step();
    MIO_EN = 1'b0; LD_Vector = 1'b0; rst_n = 1'b1;
    #1;
    test_reset();
  endtask

  initial begin
    rst_n = 1'b0; MAR = '0; MDR = '0; R_W = 1'b0; MIO_EN = 1'b0;
    KBSR = '0; UARTSR = '0; VectorMUX = '0; LD_Vector = 1'b0;
    ddr_m = '0; ie_m = 1'b0; vec_m = 8'h00;
    step(); step();
    rst_n = 1'b1;
    #1;
    test_reset();
    test_decode();
    test_display_write();
    test_scan();
    test_dsr_write();
    test_arbitration();
    test_reset_override();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lc3_io_ctrl.md
Name: lc3_io_ctrl

Overview:
- Memory-mapped I/O control slice of the LC-3 memory subsystem.
- Combines three functions:
  - address decode: read-mux select and write strobes per device;
  - the display device: DDR/DSR registers plus a 4-digit multiplexed 7-segment driver;
  - the interrupt controller: device priority arbitration and vector register.
- Sits between MAR/MDR/R_W/MIO_EN and the memory and device blocks.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is lit before the scan advances; minimum 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- MAR  in  16  current address.
- MDR  in  16  write data.
- R_W  in  1  1 = write, 0 = read.
- MIO_EN  in  1  memory/IO access enable.
- KBSR  in  16  keyboard status; bit15 ready, bit14 IE.
- UARTSR  in  16  UART status; bit15 ready, bit14 IE.
- VectorMUX  in  2  vector source select.
- LD_Vector  in  1  load Vector register.
- INMUX_Sel  out  4  read-data mux select.
- MEM_EN  out  1  RAM access.
- LD_KBSR, LD_DDR, LD_DSR, LD_SDAER, LD_SDADR, LD_SDASR, LD_SCLER, LD_UARTDR, LD_UARTSR  out  1 each  device write strobes.
- LD_SC_buffer  out  3  one-hot setcurrent write strobes.
- DSR  out  16  display status.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- an  out  4  digit anodes, active-low; an[0] = rightmost digit.
- WR_DSP  out  1  display write acknowledge.
- Vector  out  8  interrupt/exception vector.
- INT_Priority  out  3  priority of highest pending device request; 0 = none.

Behaviour:
- Decode is combinational.
- MEM_EN = MIO_EN & (MAR < xFE00).
- Read (MIO_EN & ~R_W) sets INMUX_Sel per address:
  - RAM (MAR < xFE00) 0000; KBSR xFE00 0001; KBDR xFE02 0010; DSR xFE04 0011; SWR xFE08 0100;
  - SDAER xFE0A 0101; SDADR xFE0C 0110; SDASR xFE0E 0111; SDA pin xFE10 1000; SCLER xFE12 1001;
  - SCL pin xFE14 1010; UARTSR xFE16 1011; SC buffer xFE20–xFE27 1100; change xFE28–xFE2F 1101;
  - RDCurrent xFE30–xFE37 1110.
- INMUX_Sel = 1111 in all other cases: unmapped addresses, write-only addresses (DDR xFE06, UARTDR xFE18), writes, and ~MIO_EN.
- Write (MIO_EN & R_W) asserts exactly one strobe for the address: KBSR, DSR, DDR, SDAER, SDADR, SDASR, SCLER, UARTSR, or UARTDR at the addresses above.
- LD_SC_buffer on write: [0] for xFE20–27, [1] for xFE28–2F, [2] for xFE30–37.
- Read-only and unmapped addresses produce no strobe on write.
- All strobes are 0 when ~MIO_EN or on reads.
- Display registers:
  - LD_DDR latches MDR into DDR.
  - LD_DSR latches MDR[14] into DSR[14] (interrupt enable).
  - DSR[15] (ready) clears the cycle after LD_DDR rises and sets again the cycle after LD_DDR falls.
  - DSR[13:0] = 0.
- WR_DSP is registered (LD_DDR|LD_DSR): high from the cycle after the strobe rises and held while the strobe stays high.
- Scan: a counter counts REFRESH_DIV cycles, then the digit index advances 0→1→2→3→0.
  - Lit digit i shows hex nibble DDR[4i+3:4i].
  - Only one anode is low at a time.
- Segment codes (active-low): 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110, standard hex otherwise.
- Interrupt requests: a device requests when its SR[15]&SR[14].
  - KB: priority 4, vector x80.
  - UART: priority 3, vector x82.
  - Display: priority 2, vector x81.
- INT_Priority is combinational: the highest pending priority, 0 if none.
- Vector register updates on LD_Vector per VectorMUX:
  - 00: vector of the highest pending device, or x00 if none;
  - 01: x00 (privilege violation);
  - 10: x01 (illegal opcode);
  - 11: hold.
- Vector is unchanged when LD_Vector = 0.
- Reset (rst_n = 0 at clk edge): DDR = 0, DSR = x8000, WR_DSP = 0, scan counter = 0, digit index = 0 (an = 1110), Vector = x00.
- Reset overrides simultaneous LD_DDR/LD_DSR/LD_Vector.

Test Plan:
- Read sweep: MIO_EN=1, R_W=0, MAR = x3000/xFE00/xFE02/xFE16/xFE25/xFE06/xFFFF → INMUX_Sel 0000/0001/0010/1011/1100/1111/1111; MEM_EN=1 only for x3000; no strobes.
- Write sweep: R_W=1, MAR = xFE06/xFE04/xFE18/xFE2A/xFE02 → LD_DDR/LD_DSR/LD_UARTDR/LD_SC_buffer=010/none; MIO_EN=0 → all strobes 0.
- Display write: MDR=x12AF, LD_DDR held 3 cycles → WR_DSP=1 from cycle 2, DSR[15]=0 then 1 after release. With REFRESH_DIV=2, digits cycle an = 1110/1101/1011/0111 showing F, A, 2, 1.
- DSR write: MDR=x4000 with LD_DSR → DSR = xC000; reset → DSR = x8000, an = 1110.
- Arbitration:
  - KBSR = xC000 and UARTSR = xC000 → INT_Priority = 4; LD_Vector with VectorMUX=00 → Vector = x80.
  - Clear KBSR → priority 3, vector x82.
  - Only DSR IE set → priority 2, vector x81.
  - UARTSR = x8000 only → priority 0, vector x00.
- Exception vectors: VectorMUX = 01 → x00, 10 → x01, 11 → holds previous value; LD_Vector=0 → no change.
